// File: rtl/axis_uart_rx_if.sv
// rtl/axis_uart_rx_if.sv - AXI4-Stream style word channel out of the UART receiver
//   tdata  : received word, driven by the master
//   tvalid : tdata holds an unconsumed word, driven by the master
//   tready : consumer accepts the word, driven by the slave
interface axis_uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_uart_rx.sv
// rtl/axis_uart_rx.sv - UART receiver (start, DATA_WIDTH bits MSB first, stop) to AXI4-Stream
//   clk         : clock
//   rst_async_n : asynchronous active-low reset, release synchronised internally
//   in          : asynchronous serial line, idle high
//   axis        : master word channel (tdata/tvalid/tready)
//   frame_err   : one-cycle pulse, stop bit sampled low, word dropped
//   overrun     : one-cycle pulse, word dropped because tvalid was still pending
//   parity_err  : one-cycle pulse, even parity failed, word dropped (UART_RX_PARITY_EN only)
// Macros: UART_RX_PARITY_EN adds an even-parity bit and the parity_err port;
//         SIM fixes CLKS_PER_BIT at 10.
module axis_uart_rx #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD_RATE   = 9_600,
  parameter int DATA_WIDTH  = 8
) (
  input  logic           clk,
  input  logic           rst_async_n,
  input  logic           in,
  axis_uart_rx_if.master axis,
  output logic           frame_err,
  output logic           overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic           parity_err
`endif
);

`ifdef SIM
  localparam int CLKS_PER_BIT = 10;
`else
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
`endif
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]       BIT_LAST = 4'(DATA_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // Reset asserts immediately but releases two edges later, so every flop
  // below leaves reset on the same clean edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) rst_sync <= 2'b00;
    else              rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  state_t                state, state_n;
  logic                  rx_meta, rx_s;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_n;
  logic                  tvalid_q, tvalid_n;
  logic                  frame_err_n, overrun_n;
`ifdef UART_RX_PARITY_EN
  logic                  par_bit, par_bit_n;
  logic                  parity_err_n;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      rx_meta   <= in;
      rx_s      <= rx_meta;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      tdata_q   <= tdata_n;
      tvalid_q  <= tvalid_n;
      frame_err <= frame_err_n;
      overrun   <= overrun_n;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_bit_n;
      parity_err <= parity_err_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    // Free-running bit timer; each sample point lands on the wrap.
    cnt_n       = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    tdata_n     = tdata_q;
    tvalid_n    = tvalid_q & ~axis.tready;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_n    = par_bit;
    parity_err_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_cnt_n = '0;
        if (!rx_s) state_n = START;
      end
      START: begin
        // Re-check at mid start bit; a short low pulse is silently ignored.
        if (cnt == CNT_MID) begin
          cnt_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shreg_n   = {shreg[DATA_WIDTH-2:0], rx_s};
          bit_cnt_n = bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == BIT_LAST) state_n = PARITY;
`else
          if (bit_cnt == BIT_LAST) state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          par_bit_n = rx_s;
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        // Return to IDLE at mid stop bit so a new start edge in the second
        // half of the stop bit is still caught.
        if (cnt == CNT_LAST) begin
          state_n = IDLE;
          if (!rx_s) begin
            frame_err_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{shreg, par_bit}) begin
            parity_err_n = 1'b1;
`endif
          end else if (!tvalid_q || axis.tready) begin
            tdata_n  = shreg;
            tvalid_n = 1'b1;
          end else begin
            overrun_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign axis.tdata  = tdata_q;
  assign axis.tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_uart_rx.sv
// tb/tb_axis_uart_rx.sv - scoreboard bench for axis_uart_rx with randomized frames
module tb_axis_uart_rx;
  localparam int DW   = 8;
  localparam int CLKS = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_async_n;
  logic rx_line;
  logic frame_err;
  logic overrun;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif

  axis_uart_rx_if #(.DATA_WIDTH(DW)) axis ();

  axis_uart_rx #(
    .CLK_FREQ_HZ(96_000),
    .BAUD_RATE  (9_600),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst_async_n(rst_async_n),
    .in         (rx_line),
    .axis       (axis),
    .frame_err  (frame_err),
    .overrun    (overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  int checks = 0;
  int failures = 0;
  int fe_seen = 0, ov_seen = 0, pe_seen = 0, tv_cycles = 0;
  int fe_exp = 0, ov_exp = 0, pe_exp = 0;
  logic [DW-1:0] exp_q[$];

  bit   rand_ready = 1'b0;
  logic ready_val = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Sole driver of tready: either a fixed level or a coin flip per cycle.
  initial begin
    axis.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end
  end

  // Monitor: pops the scoreboard on every transfer, counts flag pulses and
  // checks that a stalled word neither drops nor changes.
  logic          prev_v = 1'b0, prev_r = 1'b0;
  logic [DW-1:0] prev_d = '0;
  always @(negedge clk) begin
    if (axis.tvalid) tv_cycles++;
    if (frame_err) fe_seen++;
    if (overrun) ov_seen++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_seen++;
`endif
    if (prev_v && !prev_r && rst_async_n) begin
      chk("hold_tvalid", int'(axis.tvalid), 1);
      chk("hold_tdata", int'(axis.tdata), int'(prev_d));
    end
    if (axis.tvalid && axis.tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=0x%0h required=none", axis.tdata);
      end else begin
        chk("word", int'(axis.tdata), int'(exp_q.pop_front()));
      end
    end
    prev_v = axis.tvalid;
    prev_r = axis.tready;
    prev_d = axis.tdata;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic drive_bit(input logic b);
    rx_line = b;
    repeat (CLKS) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic even_par(input logic [DW-1:0] d);
    return ^d;
  endfunction

  // Serialises a frame and records what the receiver must do with it.
  // push_word=0 lets the caller predict an overrun instead of a word.
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_b,
                            input logic par_b, input bit push_word);
    logic par_ok;
    par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_ok = (par_b == even_par(d));
`endif
    if (!stop_b)      fe_exp++;
    else if (!par_ok) pe_exp++;
    else if (push_word) exp_q.push_back(d);
    else              ov_exp++;
    drive_bit(1'b0);
    for (int i = DW - 1; i >= 0; i--) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_b);
`endif
    drive_bit(stop_b);
    rx_line = 1'b1;
  endtask

  task automatic good_frame(input logic [DW-1:0] d);
    send_frame(d, 1'b1, even_par(d), 1'b1);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_flags(input string name);
    chk({name, "_frame_err"}, fe_seen, fe_exp);
    chk({name, "_overrun"}, ov_seen, ov_exp);
    chk({name, "_parity_err"}, pe_seen, pe_exp);
  endtask

  int t0;
  logic [DW-1:0] rd;
  logic          rs, rp;

  initial begin
    rst_async_n = 1'b0;
    rx_line     = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tvalid", int'(axis.tvalid), 0);
    chk("reset_tdata", int'(axis.tdata), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_overrun", int'(overrun), 0);
    @(posedge clk);
    #1;
    rst_async_n = 1'b1;
    idle(6);

    // Single frame, consumer always ready: exactly one tvalid cycle.
    t0 = tv_cycles;
    good_frame(8'hA5);
    idle(5);
    drain("a5_drain");
    chk("a5_tvalid_cycles", tv_cycles - t0, 1);
    check_flags("a5");

    // Back-to-back frames with the consumer stalled: second one overruns.
    ready_val = 1'b0;
    idle(2);
    send_frame(8'h3C, 1'b1, even_par(8'h3C), 1'b1);
    send_frame(8'hC3, 1'b1, even_par(8'hC3), 1'b0);
    @(negedge clk);
    chk("stall_tvalid", int'(axis.tvalid), 1);
    chk("stall_tdata", int'(axis.tdata), 'h3C);
    check_flags("overrun");
    ready_val = 1'b1;
    drain("overrun_drain");
    idle(3);
    chk("overrun_tvalid_low", int'(axis.tvalid), 0);

    // Bad stop bit, then a good frame.
    t0 = tv_cycles;
    send_frame(8'h55, 1'b0, even_par(8'h55), 1'b1);
    idle(CLKS);
    chk("framing_no_word", tv_cycles - t0, 0);
    good_frame(8'h0F);
    idle(5);
    drain("framing_drain");
    check_flags("framing");

    // Short glitch is ignored; a frame soon afterwards proves the FSM is idle.
    t0 = tv_cycles;
    rx_line = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle(CLKS / 2 + 3);
    chk("glitch_no_word", tv_cycles - t0, 0);
    check_flags("glitch");
    good_frame(8'h5A);
    idle(5);
    drain("glitch_drain");

    // Reset in the middle of a frame's data bits.
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_async_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midreset_tvalid", int'(axis.tvalid), 0);
    chk("midreset_tdata", int'(axis.tdata), 0);
    @(posedge clk);
    #1;
    rx_line     = 1'b1;
    rst_async_n = 1'b1;
    idle(3 * CLKS);
    good_frame(8'h81);
    idle(5);
    drain("midreset_drain");
    check_flags("midreset");

`ifdef UART_RX_PARITY_EN
    t0 = tv_cycles;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    idle(5);
    chk("parity_bad_no_word", tv_cycles - t0, 0);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    idle(5);
    drain("parity_drain");
    check_flags("parity");
`endif

    // Randomized frames, gaps and consumer backpressure.
    rand_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      rd = DW'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      rp = even_par(rd);
      if ($urandom_range(0, 5) == 0) rp = ~rp;
      send_frame(rd, rs, rp, 1'b1);
      idle(rs ? int'($urandom_range(0, 15)) : CLKS + int'($urandom_range(0, 15)));
    end
    idle(5);
    drain("random_drain");
    check_flags("random");
    rand_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
